// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared definitions for the image-RAM arbiter: phase encodings of the
// load/run/dump sequencer, requester identifiers used by the round-robin
// arbiter and read-return tag, and the default RAM geometry
// (256x256 pixels, 8 bits each).
package mem_arbiter_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 8;

    // Encoding 2'b11 is deliberately unused; the sequencer recovers to
    // PH_LOAD if it ever sees it.
    typedef enum logic [1:0] {
        PH_LOAD = 2'b00,
        PH_RUN  = 2'b01,
        PH_DUMP = 2'b10
    } phase_t;

    typedef enum logic {
        ID_CPU = 1'b0,
        ID_COM = 1'b1
    } req_id_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2
// Two-way round-robin arbiter. Grants are combinational from the
// (already eligibility-masked) requests and the last_win register; a
// lone requester is always granted, and on a tie the requester that did
// not win the previous tie is granted. last_win only moves on tied
// cycles, so uncontested traffic does not disturb fairness.
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   cpu_req, com_req   eligible requests
//   cpu_gnt, com_gnt   one-hot (or zero) grants, same cycle as request
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic cpu_req,
    input  logic com_req,
    output logic cpu_gnt,
    output logic com_gnt
);

    req_id_t last_win_reg;
    logic    contested;

    assign contested = cpu_req & com_req;

    always_comb begin
        cpu_gnt = 1'b0;
        com_gnt = 1'b0;
        if (contested) begin
            if (last_win_reg == ID_COM) begin
                cpu_gnt = 1'b1;
            end else begin
                com_gnt = 1'b1;
            end
        end else begin
            cpu_gnt = cpu_req;
            com_gnt = com_req;
        end
    end

    // Reset value ID_COM makes the cpu win the very first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_win_reg <= ID_COM;
        end else if (contested) begin
            last_win_reg <= cpu_gnt ? ID_CPU : ID_COM;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares the single-port image RAM between the down-sampling core (cpu)
// and the serial unit (com). A three-phase sequencer gives com exclusive
// access while a frame is loaded (LOAD), shares the RAM round-robin while
// the core runs (RUN) and hands it back to com for the result dump (DUMP).
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   com_over, cpu_done             one-cycle phase pulses
//   cpu_req/we/addr/wdata/gnt      core access port
//   cpu_rvalid, cpu_rdata          core read return (1 cycle after grant)
//   com_*                          serial unit port, same shape as cpu_*
//   mem_en/we/addr/wdata, mem_rdata  RAM macro side
//   phase                          current phase (00 LOAD, 01 RUN, 10 DUMP)
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              com_over,
    input  logic              cpu_done,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              com_req,
    input  logic              com_we,
    input  logic [ADDR_W-1:0] com_addr,
    input  logic [DATA_W-1:0] com_wdata,
    output logic              com_gnt,
    output logic              com_rvalid,
    output logic [DATA_W-1:0] com_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        phase
);

    phase_t  phase_reg;
    phase_t  phase_next;
    logic    rd_pending_reg;
    req_id_t rd_owner_reg;
    logic    cpu_elig;

    // ---------------- phase sequencer ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_reg <= PH_LOAD;
        end else begin
            phase_reg <= phase_next;
        end
    end

    // Pulses that do not belong to the current phase are ignored.
    always_comb begin
        phase_next = phase_reg;
        case (phase_reg)
            PH_LOAD: if (com_over) phase_next = PH_RUN;
            PH_RUN:  if (cpu_done) phase_next = PH_DUMP;
            PH_DUMP: if (com_over) phase_next = PH_LOAD;
            default: phase_next = PH_LOAD;
        endcase
    end

    assign phase = phase_reg;

    // ---------------- arbitration ----------------
    // com may use the RAM in every phase; the core only while running.
    // Grants use the current phase, so a pulse cycle still arbitrates
    // under the old phase.
    assign cpu_elig = (phase_reg == PH_RUN);

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .cpu_req (cpu_req & cpu_elig),
        .com_req (com_req),
        .cpu_gnt (cpu_gnt),
        .com_gnt (com_gnt)
    );

    // ---------------- RAM-side mux ----------------
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (com_gnt) begin
            mem_en    = 1'b1;
            mem_we    = com_we;
            mem_addr  = com_addr;
            mem_wdata = com_wdata;
        end
    end

    // ---------------- read return ----------------
    // The owner tag travels alongside the RAM's one-cycle read latency, so
    // a read granted in the last cycle of a phase still returns to its
    // owner after the phase has changed. Reset drops any pending return.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_pending_reg <= 1'b0;
            rd_owner_reg   <= ID_COM;
        end else begin
            rd_pending_reg <= mem_en & ~mem_we;
            rd_owner_reg   <= cpu_gnt ? ID_CPU : ID_COM;
        end
    end

    assign cpu_rvalid = rd_pending_reg && (rd_owner_reg == ID_CPU);
    assign com_rvalid = rd_pending_reg && (rd_owner_reg == ID_COM);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign com_rdata  = com_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. A behavioural RAM returns a fixed
// address-derived pattern one cycle after a read. Grants and datapath are
// checked inline by each scenario task; every expected read return is
// pushed to a scoreboard queue when the read is expected to be granted and
// popped by a monitor in the following cycle.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW = 16;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          com_over, cpu_done;
    logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          com_req, com_we, com_gnt, com_rvalid;
    logic [AW-1:0] com_addr;
    logic [DW-1:0] com_wdata, com_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [1:0]    phase;

    typedef struct {
        logic          owner_com;
        logic [DW-1:0] data;
    } sb_t;

    sb_t     sb_q[$];
    sb_t     mon_e;
    logic    ev_cpu, ev_com;
    logic [DW-1:0] ed_cpu, ed_com;
    bit      sb_on = 1'b0;
    req_id_t exp_last;
    int      total = 0;
    int      bad = 0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .com_over(com_over), .cpu_done(cpu_done),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .cpu_rdata(cpu_rdata),
        .com_req(com_req), .com_we(com_we), .com_addr(com_addr),
        .com_wdata(com_wdata), .com_gnt(com_gnt), .com_rvalid(com_rvalid),
        .com_rdata(com_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .phase(phase)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // RAM contents are a fixed pattern; writes are accepted and dropped.
    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= pat(mem_addr);
    end

    // Read-return monitor: the queue head must appear exactly this cycle.
    always begin
        @(posedge clk);
        #1;
        if (sb_on) begin
            ev_cpu = 1'b0; ev_com = 1'b0; ed_cpu = '0; ed_com = '0;
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                if (mon_e.owner_com) begin
                    ev_com = 1'b1; ed_com = mon_e.data;
                end else begin
                    ev_cpu = 1'b1; ed_cpu = mon_e.data;
                end
            end
            total++;
            if (cpu_rvalid !== ev_cpu || com_rvalid !== ev_com) begin
                bad++;
                $display("FAIL rvalid @%0t: cpu=%b com=%b, expected cpu=%b com=%b",
                         $time, cpu_rvalid, com_rvalid, ev_cpu, ev_com);
            end
            total++;
            if (cpu_rdata !== ed_cpu || com_rdata !== ed_com) begin
                bad++;
                $display("FAIL rdata @%0t: cpu=%h com=%h, expected cpu=%h com=%h",
                         $time, cpu_rdata, com_rdata, ed_cpu, ed_com);
            end
        end
    end

    task automatic set_idle();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        com_req = 0; com_we = 0; com_addr = '0; com_wdata = '0;
        com_over = 0; cpu_done = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        total++;
        if (phase !== 2'b00) begin bad++; $display("FAIL reset_phase: got %b want 00", phase); end
        total++;
        if (cpu_gnt !== 1'b0 || com_gnt !== 1'b0 || mem_en !== 1'b0) begin
            bad++; $display("FAIL reset_gnt: cpu_gnt=%b com_gnt=%b mem_en=%b want 0 0 0", cpu_gnt, com_gnt, mem_en);
        end
        total++;
        if (cpu_rvalid !== 1'b0 || com_rvalid !== 1'b0 || cpu_rdata !== 8'h00 || com_rdata !== 8'h00) begin
            bad++; $display("FAIL reset_rd: rvalid=%b/%b rdata=%h/%h want 0", cpu_rvalid, com_rvalid, cpu_rdata, com_rdata);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_last = ID_COM;
        sb_q.delete();
        sb_on = 1'b1;
        tick();
    endtask

    task automatic test_load_exclusive();
        cpu_req = 1; cpu_addr = 16'h0010;
        com_req = 1; com_we = 1; com_addr = 16'h0020; com_wdata = 8'hA5;
        #1;
        total++;
        if (com_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin
            bad++; $display("FAIL load_gnt: cpu_gnt=%b com_gnt=%b want 0 1", cpu_gnt, com_gnt);
        end
        total++;
        if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0020 || mem_wdata !== 8'hA5) begin
            bad++; $display("FAIL load_mem: en=%b we=%b addr=%h wdata=%h want 1 1 0020 a5", mem_en, mem_we, mem_addr, mem_wdata);
        end
        tick();
        set_idle();
        cpu_req = 1; cpu_addr = 16'h0011;
        #1;
        total++;
        if (cpu_gnt !== 1'b0 || mem_en !== 1'b0 || mem_addr !== 16'h0000) begin
            bad++; $display("FAIL load_cpu_alone: cpu_gnt=%b mem_en=%b addr=%h want 0 0 0000", cpu_gnt, mem_en, mem_addr);
        end
        tick();
        set_idle();
        cpu_done = 1;
        tick();
        set_idle();
        total++;
        if (phase !== 2'b00) begin bad++; $display("FAIL load_cpu_done_ignored: phase=%b want 00", phase); end
    endtask

    task automatic test_read_at_phase_change();
        com_req = 1; com_addr = 16'h0100; com_over = 1;
        #1;
        total++;
        if (com_gnt !== 1'b1 || mem_we !== 1'b0) begin
            bad++; $display("FAIL edge_read_gnt: com_gnt=%b mem_we=%b want 1 0", com_gnt, mem_we);
        end
        sb_q.push_back('{owner_com: 1'b1, data: pat(16'h0100)});
        tick();
        set_idle();
        total++;
        if (phase !== 2'b01) begin bad++; $display("FAIL to_run: phase=%b want 01", phase); end
    endtask

    task automatic test_com_only();
        for (int i = 0; i < 3; i++) begin
            com_req = 1; com_addr = 16'h0200 + 16'(i);
            #1;
            total++;
            if (com_gnt !== 1'b1 || cpu_gnt !== 1'b0 || mem_addr !== 16'h0200 + 16'(i)) begin
                bad++; $display("FAIL com_only[%0d]: cpu_gnt=%b com_gnt=%b addr=%h", i, cpu_gnt, com_gnt, mem_addr);
            end
            sb_q.push_back('{owner_com: 1'b1, data: pat(16'h0200 + 16'(i))});
            tick();
        end
        cpu_req = 1; cpu_addr = 16'h0300; com_addr = 16'h0203;
        #1;
        total++;
        if (cpu_gnt !== 1'b1 || com_gnt !== 1'b0 || mem_addr !== 16'h0300) begin
            bad++; $display("FAIL first_tie: cpu_gnt=%b com_gnt=%b addr=%h want 1 0 0300", cpu_gnt, com_gnt, mem_addr);
        end
        sb_q.push_back('{owner_com: 1'b0, data: pat(16'h0300)});
        exp_last = ID_CPU;
        tick();
        set_idle();
    endtask

    task automatic test_alternate();
        logic [AW-1:0] ca, ma;
        logic          exp_cpu;
        ca = 16'h0400;
        ma = 16'h0500;
        for (int i = 0; i < 6; i++) begin
            cpu_req = 1; cpu_addr = ca;
            com_req = 1; com_addr = ma;
            #1;
            exp_cpu = (exp_last == ID_COM);
            total++;
            if (cpu_gnt !== exp_cpu || com_gnt !== !exp_cpu || mem_addr !== (exp_cpu ? ca : ma)) begin
                bad++; $display("FAIL alternate[%0d]: cpu_gnt=%b com_gnt=%b addr=%h want cpu_gnt=%b addr=%h",
                                i, cpu_gnt, com_gnt, mem_addr, exp_cpu, exp_cpu ? ca : ma);
            end
            if (exp_cpu) begin
                sb_q.push_back('{owner_com: 1'b0, data: pat(ca)});
                exp_last = ID_CPU;
                ca = ca + 16'd1;
            end else begin
                sb_q.push_back('{owner_com: 1'b1, data: pat(ma)});
                exp_last = ID_COM;
                ma = ma + 16'd1;
            end
            tick();
        end
        set_idle();
    endtask

    task automatic test_phase_pulses();
        com_over = 1;
        tick();
        set_idle();
        total++;
        if (phase !== 2'b01) begin bad++; $display("FAIL run_com_over_ignored: phase=%b want 01", phase); end
        cpu_req = 1; cpu_addr = 16'h0600; cpu_done = 1;
        #1;
        total++;
        if (cpu_gnt !== 1'b1) begin bad++; $display("FAIL done_cycle_gnt: cpu_gnt=%b want 1", cpu_gnt); end
        sb_q.push_back('{owner_com: 1'b0, data: pat(16'h0600)});
        tick();
        set_idle();
        total++;
        if (phase !== 2'b10) begin bad++; $display("FAIL to_dump: phase=%b want 10", phase); end
        for (int i = 0; i < 3; i++) begin
            cpu_req = 1; cpu_addr = 16'h0601;
            com_req = (i == 1); com_addr = 16'h0700;
            #1;
            total++;
            if (cpu_gnt !== 1'b0 || com_gnt !== (i == 1)) begin
                bad++; $display("FAIL dump_excl[%0d]: cpu_gnt=%b com_gnt=%b", i, cpu_gnt, com_gnt);
            end
            if (i == 1) sb_q.push_back('{owner_com: 1'b1, data: pat(16'h0700)});
            tick();
        end
        com_req = 0; com_over = 1;
        #1;
        total++;
        if (cpu_gnt !== 1'b0) begin bad++; $display("FAIL dump_over_gnt: cpu_gnt=%b want 0", cpu_gnt); end
        tick();
        com_over = 0;
        #1;
        total++;
        if (phase !== 2'b00 || cpu_gnt !== 1'b0) begin
            bad++; $display("FAIL back_to_load: phase=%b cpu_gnt=%b want 00 0", phase, cpu_gnt);
        end
        tick();
        set_idle();
    endtask

    task automatic test_reset_inflight();
        com_over = 1;
        tick();
        set_idle();
        // Tie 1: exp_last is cpu here, so com wins.
        cpu_req = 1; cpu_addr = 16'h0800; com_req = 1; com_addr = 16'h0900;
        #1;
        total++;
        if (com_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin
            bad++; $display("FAIL pre_rst_tie1: cpu_gnt=%b com_gnt=%b want 0 1", cpu_gnt, com_gnt);
        end
        sb_q.push_back('{owner_com: 1'b1, data: pat(16'h0900)});
        tick();
        // Tie 2: cpu wins, leaving last_win at cpu; its read is cut by reset.
        com_addr = 16'h0901;
        #1;
        total++;
        if (cpu_gnt !== 1'b1 || com_gnt !== 1'b0) begin
            bad++; $display("FAIL pre_rst_tie2: cpu_gnt=%b com_gnt=%b want 1 0", cpu_gnt, com_gnt);
        end
        sb_on = 1'b0;
        tick();
        set_idle();
        total++;
        if (cpu_rvalid !== 1'b1) begin bad++; $display("FAIL inflight_rvalid: cpu_rvalid=%b want 1", cpu_rvalid); end
        rst = 1'b0;
        #1;
        total++;
        if (cpu_rvalid !== 1'b0 || com_rvalid !== 1'b0 || cpu_rdata !== 8'h00 || phase !== 2'b00) begin
            bad++; $display("FAIL async_rst: rvalid=%b/%b rdata=%h phase=%b want 0 0 00 00",
                            cpu_rvalid, com_rvalid, cpu_rdata, phase);
        end
        tick();
        tick();
        rst = 1'b1;
        exp_last = ID_COM;
        tick();
        total++;
        if (cpu_rvalid !== 1'b0 || com_rvalid !== 1'b0 || cpu_rdata !== 8'h00 || com_rdata !== 8'h00) begin
            bad++; $display("FAIL post_rst_stale: rvalid=%b/%b rdata=%h/%h want 0", cpu_rvalid, com_rvalid, cpu_rdata, com_rdata);
        end
        sb_q.delete();
        sb_on = 1'b1;
        com_over = 1;
        tick();
        set_idle();
        cpu_req = 1; cpu_addr = 16'h0A00; com_req = 1; com_addr = 16'h0B00;
        #1;
        total++;
        if (cpu_gnt !== 1'b1 || com_gnt !== 1'b0) begin
            bad++; $display("FAIL post_rst_tie: cpu_gnt=%b com_gnt=%b want 1 0", cpu_gnt, com_gnt);
        end
        sb_q.push_back('{owner_com: 1'b0, data: pat(16'h0A00)});
        tick();
        set_idle();
        tick();
    endtask

    initial begin
        set_idle();
        rst = 1'b0;
        test_reset();
        test_load_exclusive();
        test_read_at_phase_change();
        test_com_only();
        test_alternate();
        test_phase_pulses();
        test_reset_inflight();
        tick();
        total++;
        if (sb_q.size() != 0) begin
            bad++; $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
        end
        sb_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
